// File: rtl/dds_wavegen_if.sv
// Control and sample bus of the DDS oscillator.
// The master drives run/sync/mode/tuning; the slave returns samples and phase.
interface dds_wavegen_if #(
  parameter int PHASE_W = 24,
  parameter int OUT_W   = 8
);
  logic               en;
  logic               sync;
  logic [1:0]         mode;
  logic [PHASE_W-1:0] fcw;
  logic [OUT_W-1:0]   wave_out;
  logic               wave_valid;
  logic [PHASE_W-1:0] phase_out;

  modport master (
    output en, sync, mode, fcw,
    input  wave_out, wave_valid, phase_out
  );

  modport slave (
    input  en, sync, mode, fcw,
    output wave_out, wave_valid, phase_out
  );
endinterface

// File: rtl/dds_wavegen.sv
// Direct-digital-synthesis oscillator: divided sample tick, phase accumulator,
// and a two-stage pipeline producing sine/square/saw/triangle in offset binary.
module dds_wavegen #(
  parameter int PHASE_W    = 24,
  parameter int OUT_W      = 8,
  parameter int QTR_AW     = 6,
  parameter int SAMPLE_DIV = 4630
) (
  input  logic        clk,
  input  logic        rst,
  dds_wavegen_if.slave bus
);

  localparam int unsigned N     = 2 ** QTR_AW;
  localparam int unsigned MID   = 2 ** (OUT_W - 1);
  localparam int          CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  // Only the phase MSBs that any waveform reads travel down the pipeline.
  localparam int          SW    = (QTR_AW + 2 > OUT_W + 1) ? QTR_AW + 2 : OUT_W + 1;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [OUT_W-1:0] MID_V    = OUT_W'(MID);

  if (PHASE_W < QTR_AW + 2 || PHASE_W < OUT_W + 1 || SAMPLE_DIV < 1) begin : g_param_check
    $error("dds_wavegen: inconsistent PHASE_W/OUT_W/QTR_AW/SAMPLE_DIV");
  end

  // round((mid-1) * sin(pi/2 * i/N)) using a Taylor series, evaluated at elaboration.
  function automatic logic [OUT_W-1:0] qtr_entry(input int unsigned i);
    real x;
    real term;
    real s;
    x    = 3.14159265358979323846 / 2.0 * real'(i) / real'(N);
    term = x;
    s    = x;
    for (int unsigned k = 1; k < 10; k++) begin
      term = -term * x * x / (real'(2 * k) * real'(2 * k + 1));
      s    = s + term;
    end
    return OUT_W'($rtoi(real'(MID - 1) * s + 0.5));
  endfunction

  logic [OUT_W-1:0] qtab [N+1];

  for (genvar g = 0; g <= int'(N); g++) begin : g_qtab
    localparam logic [OUT_W-1:0] QV = qtr_entry(g);
    assign qtab[g] = QV;
  end

  logic [CNT_W-1:0]   div_cnt;
  logic               tick;
  logic               capture;
  logic [PHASE_W-1:0] phase;

  assign tick    = (div_cnt == DIV_LAST);
  assign capture = tick & bus.en;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
    end else if (bus.sync) begin
      phase <= '0;
    end else if (capture) begin
      phase <= phase + bus.fcw;
    end
  end

  logic          s1_valid;
  logic [SW-1:0] s1_phase;
  logic [1:0]    s1_mode;

  // Stage 1 sees the pre-update phase, so a tick coinciding with sync keeps its sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_phase <= '0;
      s1_mode  <= '0;
    end else begin
      s1_valid <= capture;
      if (capture) begin
        s1_phase <= phase[PHASE_W-1 -: SW];
        s1_mode  <= bus.mode;
      end
    end
  end

  logic [1:0]        quad;
  logic [QTR_AW-1:0] idx;
  logic [QTR_AW:0]   idx_fwd;
  logic [QTR_AW:0]   idx_rev;
  logic [OUT_W-1:0]  qval;
  logic [OUT_W-1:0]  tri_a;
  logic [OUT_W-1:0]  sample;

  always_comb begin
    quad    = s1_phase[SW-1 -: 2];
    idx     = s1_phase[SW-3 -: QTR_AW];
    idx_fwd = {1'b0, idx};
    idx_rev = (QTR_AW + 1)'(N) - idx_fwd;
    qval    = quad[0] ? qtab[idx_rev] : qtab[idx_fwd];
    tri_a   = s1_phase[SW-2 -: OUT_W];
    sample  = MID_V;
    case (s1_mode)
      2'd0:    sample = quad[1] ? (MID_V - qval) : (MID_V + qval);
      2'd1:    sample = s1_phase[SW-1] ? '0 : '1;
      2'd2:    sample = s1_phase[SW-1 -: OUT_W];
      default: sample = s1_phase[SW-1] ? ~tri_a : tri_a;
    endcase
  end

  logic [OUT_W-1:0] wave_q;
  logic             valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wave_q  <= MID_V;
      valid_q <= 1'b0;
    end else begin
      valid_q <= s1_valid;
      if (s1_valid) begin
        wave_q <= sample;
      end
    end
  end

  assign bus.wave_out   = wave_q;
  assign bus.wave_valid = valid_q;
  assign bus.phase_out  = phase;

endmodule

// File: doc/dds_wavegen.md
Name: dds_wavegen

Overview:
- Parametrised direct-digital-synthesis oscillator. It replaces the fixed-rate, fixed-table 8-bit sine generator.
- A phase accumulator, advanced by a runtime tuning word on an internal sample tick, drives four waveform modes: sine from a quarter-wave table, square, saw and triangle.
- Output is offset-binary of parametrised width, for the PMOD R2R DAC or for downstream mixing/envelope blocks in the synth.

Parameters:
- PHASE_W, 24: phase accumulator and tuning word width. Must satisfy PHASE_W >= QTR_AW+2 and PHASE_W >= OUT_W+1.
- OUT_W, 8: output sample width.
- QTR_AW, 6: quarter-wave table address width. Table has N+1 entries, N = 2^QTR_AW.
- SAMPLE_DIV, 4630: clk cycles per sample tick, minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable
- sync  in  1  hard-sync; phase restart to 0
- mode  in  2  0 sine, 1 square, 2 saw, 3 triangle
- fcw  in  PHASE_W  frequency control word, added to phase each tick
- wave_out  out  OUT_W  current sample, offset binary
- wave_valid  out  1  one-clk pulse when wave_out updates
- phase_out  out  PHASE_W  accumulator value (debug / chaining)

Behaviour:
- Reset (rst=1 at a clk edge): divider counter=0, phase=0, pipeline valid bits=0, wave_out=2^(OUT_W-1), wave_valid=0. A mid-operation reset takes effect at the next edge and discards in-flight samples.
- Divider: counter runs 0..SAMPLE_DIV-1 and wraps, independent of en. tick=1 in the cycle where counter==SAMPLE_DIV-1. SAMPLE_DIV=1 means tick every cycle.
- Accumulator, priority order:
  - sync=1: phase<=0.
  - else tick&en: phase<=phase+fcw, mod 2^PHASE_W. Wrap-around is silent.
  - else: hold.
- Sample capture: in tick&en cycle k, stage 1 registers the pre-update phase and mode.
  - Stage 2 registers the computed sample into wave_out and pulses wave_valid in cycle k+2. Fixed latency 2; fully pipelined.
  - A tick coinciding with sync still emits the sample of the pre-sync phase.
- en=0: no capture, no wave_valid. wave_out holds its last value. Samples already in the pipeline still complete.
- mode and fcw changes apply at the next tick; there is no glitch filtering.
- Waveforms use P=phase (stage 1), mid=2^(OUT_W-1), max=2^OUT_W-1.
  - sine:
    - Quadrant q=P[PHASE_W-1:PHASE_W-2]; idx=P[PHASE_W-3 -: QTR_AW].
    - Table Q[i]=round((mid-1)*sin(pi/2*i/N)), i=0..N, computed at elaboration. Q[0]=0, Q[N]=mid-1.
    - q0: mid+Q[idx]. q1: mid+Q[N-idx]. q2: mid-Q[idx]. q3: mid-Q[N-idx].
    - Output range 1..max; no overflow.
  - square: P MSB=0 -> max; P MSB=1 -> 0.
  - saw: P[PHASE_W-1 -: OUT_W].
  - triangle: a=P[PHASE_W-2 -: OUT_W]; out = P MSB ? ~a : a. Rises 0..max, then falls max..0.
- phase_out equals the phase register (combinational from register).

Test Plan (OUT_W=8, PHASE_W=12, QTR_AW=4, SAMPLE_DIV=1 unless noted):
- Reset: hold rst 3 cycles, release with en=0 -> wave_out=128, wave_valid=0, phase_out=0 indefinitely.
- Sine quadrants: mode=0, fcw=1024, en=1 -> wave_valid every cycle, first valid 2 cycles after the first tick. Samples 128,255,128,1 repeating; phase_out 1024,2048,3072,0.
- Square/saw: mode=1, fcw=1024 -> 255,255,0,0. Then mode=2, fcw=512 from phase 0 -> 0,32,64,...,224,0 (wrap at phase 4096).
- Triangle: mode=3, fcw=512 from phase 0 -> 0,64,128,192,255,191,127,63,0.
- Divider/enable: SAMPLE_DIV=5, fcw=100.
  - wave_valid exactly once per 5 clks.
  - Drop en for 12 clks -> no pulses, wave_out frozen, phase frozen.
  - Re-enable -> phase resumes from its held value.
- Sync and reset mid-stream:
  - sync on a tick at phase 2048 -> that sample uses 2048, next phase_out=0, following sample from phase 0 (sine 128).
  - rst asserted while two samples are in flight -> no wave_valid after reset; wave_out=128.
